// File: rtl/neocore_pkg.sv
// neocore_pkg: shared types and constants for the instruction fetch path.
//   FETCH_BYTES        bytes per fetch window returned to the fetch unit
//   WORD_BYTES         bytes per SRAM word
//   STAGE_WORDS/BITS   staging register geometry (worst case: 5 SRAM words)
//   imem_resp_state_t  fetch responder FSM states
//   words_needed()     SRAM words needed for a window at a given byte offset
package neocore_pkg;

    localparam int FETCH_BYTES = 16;
    localparam int WORD_BYTES  = 4;
    localparam int STAGE_WORDS = FETCH_BYTES / WORD_BYTES + 1;
    localparam int STAGE_BITS  = STAGE_WORDS * WORD_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } imem_resp_state_t;

    // An aligned window fits in four words; any other offset straddles a fifth.
    function automatic logic [2:0] words_needed(input logic [1:0] offset);
        return (offset == 2'd0) ? 3'd4 : 3'd5;
    endfunction

endpackage

// File: rtl/fetch_window_align.sv
// fetch_window_align: selects a 16-byte big-endian window out of the 20-byte
// staging register, starting at the byte offset of the requested address.
//   staging  in   160  word i of the window occupies bits [159-32i -: 32]
//   offset   in   2    byte offset of the window start within word 0
//   window   out  128  bits [127:120] = first byte of the window
module fetch_window_align
    import neocore_pkg::*;
(
    input  logic [STAGE_BITS-1:0]    staging,
    input  logic [1:0]               offset,
    output logic [FETCH_BYTES*8-1:0] window
);

    // Taking the top 128 bits of (staging << 8*offset) is the same as a
    // 128-bit slice starting 8*offset bits below the MSB.
    assign window = staging[STAGE_BITS - 1 - 8 * int'(offset) -: FETCH_BYTES * 8];

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: serves 16-byte big-endian instruction windows at any
// byte address by reading four or five consecutive words from a 32-bit
// synchronous SRAM and shifting them into place.
//   clk, rst     clock; asynchronous active-high reset
//   mem_req      fetch request, held by the requester until the ack
//   mem_addr     byte address of window byte 0
//   mem_rdata    128-bit window, valid while mem_ack is high
//   mem_ack      one-cycle completion pulse
//   sram_en      SRAM read enable
//   sram_addr    SRAM word address
//   sram_rdata   SRAM read data, one cycle after sram_en
module imem_fetch_responder
    import neocore_pkg::*;
#(
    parameter  int MEM_WORDS = 16384,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_req,
    input  logic [31:0]              mem_addr,
    output logic [FETCH_BYTES*8-1:0] mem_rdata,
    output logic                     mem_ack,
    output logic                     sram_en,
    output logic [AW-1:0]            sram_addr,
    input  logic [31:0]              sram_rdata
);

    imem_resp_state_t        state, state_next;
    logic [31:0]             req_addr;     // latched request address A
    logic [2:0]              word_cnt;     // SRAM words issued so far
    logic [STAGE_BITS-1:0]   staging, staging_next;
    logic [FETCH_BYTES*8-1:0] window_next;

    logic [1:0]    offset;
    logic [AW-1:0] base_word;
    logic [2:0]    n_words;
    logic          abort;
    logic          capture;
    logic [2:0]    capture_idx;

    assign offset    = req_addr[1:0];
    assign base_word = req_addr[AW+1:2];
    assign n_words   = words_needed(offset);

    // The requester moved on (branch flush or PC advance): drop the window.
    assign abort = !mem_req || (mem_addr != req_addr);

    // Word i returns two cycles after its issue cycle, so during ISSUE the
    // returning word trails the issue count by two; in DRAIN only the last
    // word is still in flight.
    assign capture     = !abort && ((state == ISSUE && word_cnt >= 3'd2) || state == DRAIN);
    assign capture_idx = (state == DRAIN) ? word_cnt - 3'd1 : word_cnt - 3'd2;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        staging_next = staging;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_next   = ISSUE;
                    // Word 4 stays zero for aligned windows.
                    staging_next = '0;
                end
            end
            ISSUE: begin
                if (abort)
                    state_next = IDLE;
                else if (word_cnt == n_words)
                    state_next = DRAIN;
            end
            DRAIN:   state_next = abort ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (capture)
            staging_next[STAGE_BITS - 1 - 32 * int'(capture_idx) -: 32] = sram_rdata;
    end

    // The window is aligned from the staging value that already includes the
    // final word, so mem_rdata is registered on the DRAIN->RESP edge and is
    // valid in the same cycle as the ack.
    fetch_window_align u_align (
        .staging (staging_next),
        .offset  (offset),
        .window  (window_next)
    );

    // NOTE: state uses non-blocking assignments so every register in this
    // block samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            word_cnt  <= '0;
            // NOTE: the staging register is plain flops, not a memory, so
            // clearing it on reset is cheap and keeps stale bytes out.
            staging   <= '0;
            sram_en   <= 1'b0;
            sram_addr <= '0;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state   <= state_next;
            staging <= staging_next;
            mem_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (mem_req) begin
                        req_addr  <= mem_addr;
                        sram_en   <= 1'b1;
                        sram_addr <= mem_addr[AW+1:2];
                        word_cnt  <= 3'd1;
                    end
                end
                ISSUE: begin
                    if (abort || word_cnt == n_words) begin
                        sram_en <= 1'b0;
                    end else begin
                        // AW-bit sum wraps the word index within the SRAM.
                        sram_addr <= base_word + AW'(word_cnt);
                        word_cnt  <= word_cnt + 3'd1;
                    end
                end
                DRAIN: begin
                    sram_en <= 1'b0;
                    if (!abort) begin
                        mem_rdata <= window_next;
                        mem_ack   <= 1'b1;
                    end
                end
                default: sram_en <= 1'b0;
            endcase
        end
    end

endmodule
